accel_uart_framer: RTL and testbench
====================================

# accel_uart_framer

Packetizes one accelerometer sample (signed 16-bit X, Y, Z) into an 8-byte UART frame and drives the byte-level transmitter one byte at a time. It sits directly upstream of `uart_tx`, which is instantiated with `gonbitsys = 8`. The framer supplies `tx_data_o` and `tx_start_o` to the transmitter and consumes its `tx_done_tick_o`. A one-deep pending buffer absorbs a sample that arrives while a frame is in flight.

## Interface
- `P_HEADER`, 8'hA5: first byte of every frame.
- `P_GAP_CYCLES`, 0: idle clock cycles inserted after each frame's last done tick (0 to 255).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid_i`  in  1  one-cycle strobe; X, Y, Z are valid in the same cycle.
- `x_i`, `y_i`, `z_i`  in  16 each  signed axis samples.
- `tx_done_tick_i`  in  1  one-cycle pulse from the transmitter when a byte, including its stop bits, is complete.
- `tx_data_o`  out  8  byte presented to the transmitter.
- `tx_start_o`  out  1  one-cycle start strobe to the transmitter.
- `busy_o`  out  1  high whenever the state is not S_IDLE.
- `frame_done_o`  out  1  one-cycle pulse after the last byte of a frame completes.
- `drop_cnt_o`  out  8  count of samples lost to pending-buffer overwrite; saturates at 255.

## Operation
- **Frame byte order, index 0 to 7:** `P_HEADER`, X[15:8], X[7:0], Y[15:8], Y[7:0], Z[15:8], Z[7:0], CHK.
  - CHK is the XOR of bytes 0 to 6.
  - The frame register, including CHK, is computed once at load time and held for the whole frame.
- **S_IDLE:**
  - If the pending buffer is valid: load the frame from pending and clear pending. If `sample_valid_i` is high in the same cycle, that sample goes into pending; nothing is dropped.
  - Else, if `sample_valid_i` is high: load the frame directly from the inputs.
  - On a load: idx=0, go to S_START.
- **S_START:**
  - `tx_start_o`=1 for exactly this one cycle.
  - `tx_data_o` = frame[idx], registered on entry to S_START and held until the next S_START.
  - Next state: S_WAIT.
- **S_WAIT:** on `tx_done_tick_i`:
  - If idx<7: idx+1, go to S_START.
  - If idx==7: assert `frame_done_o` in the next cycle. Go to S_GAP if `P_GAP_CYCLES`>0, else to S_IDLE.
- **S_GAP:** count `P_GAP_CYCLES` cycles, then go to S_IDLE.
- **Sample arriving while not in S_IDLE:**
  - It is written to pending.
  - If pending was already valid, it is overwritten (newest wins) and `drop_cnt_o` increments, saturating at 255.
- **Ignored `tx_done_tick_i`:** a tick in S_IDLE, S_START or S_GAP has no effect.
- **Transmitter protocol:** the framer never issues `tx_start_o` before the done tick of the previous byte. This matches the transmitter, which accepts a start only in its idle state.

## Timing
- **Reset values, asynchronous, while `rst_n`=0:**
  - state=S_IDLE, idx=0, pending cleared.
  - `tx_data_o`=8'h00, `tx_start_o`=0, `busy_o`=0, `frame_done_o`=0, `drop_cnt_o`=0.
- **Reset mid-frame:** the frame is abandoned with no completion pulse. The first frame after release starts again from the header.
- **Start latency:** `sample_valid_i` sampled at edge N in S_IDLE gives `tx_start_o`=1 and `tx_data_o`=`P_HEADER` during cycle N+1.
- **Byte-to-byte:** a done tick sampled at edge M gives `tx_start_o` for the next byte during cycle M+1.
- **End of frame:** the last done tick at edge M gives `frame_done_o`=1 during cycle M+1.
  - With `P_GAP_CYCLES`=0, the framer is in S_IDLE in cycle M+1. A pending sample then produces its header `tx_start_o` at M+2.
  - With `P_GAP_CYCLES`=G, the header of the next frame cannot start before cycle M+G+2.
- **Frame duration:** 8 byte times plus 8 cycles of handshake overhead, plus the gap.
- **Busy:** `busy_o` rises in the cycle after the load and falls in the cycle the state returns to S_IDLE.

## Test plan
- **Basic frame:** reset, then one strobe with X=16'h1234, Y=16'hABCD, Z=16'h00FF, bench transmitter model answering each start.
  - Required: bytes A5, 12, 34, AB, CD, 00, FF, 1A in that order.
  - Required: `frame_done_o` pulses once, one cycle after the 8th done tick.
- **Handshake cycle count:** model returns `tx_done_tick_i` 10 cycles after each start.
  - Required: each `tx_start_o` is exactly one cycle wide and falls 1 cycle after the prior done tick.
  - Required: `tx_data_o` is stable throughout each byte.
- **Pending buffer:** strobe sample A, then strobe B while byte 3 is in flight.
  - Required: frame B starts 1 cycle after A's `frame_done_o` cycle (`P_GAP_CYCLES`=0).
  - Required: `drop_cnt_o` stays 0.
- **Overwrite and saturation:** strobe A, then B, C, D during frame A.
  - Required: the next frame carries D and `drop_cnt_o`=2.
  - Then force 300 overwrites: required `drop_cnt_o`=255.
- **Gap and spurious ticks:** with `P_GAP_CYCLES`=4, back-to-back pending frames start with header 6 cycles after the last done tick. A `tx_done_tick_i` injected in S_IDLE produces no `tx_start_o`.
- **Reset mid-frame:** assert `rst_n`=0 during byte 5.
  - Required: all outputs go to reset values immediately and `frame_done_o` does not pulse.
  - Required: after release, a new strobe produces a frame starting with A5.

Source files
------------

// File: rtl/accel_uart_framer.sv
// Accelerometer sample framer: packs signed X/Y/Z into an 8-byte frame
// (header, six data bytes, XOR checksum) and feeds a byte-level UART transmitter.
module accel_uart_framer #(
  parameter logic [7:0] P_HEADER     = 8'hA5,
  parameter int         P_GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid_i,
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] y_i,
  input  logic signed [15:0] z_i,
  input  logic               tx_done_tick_i,
  output logic        [7:0]  tx_data_o,
  output logic               tx_start_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic        [7:0]  drop_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;
  typedef logic [0:7][7:0] frame_t;

  localparam logic [7:0] GAP_LOAD = (P_GAP_CYCLES > 0) ? 8'(P_GAP_CYCLES - 1) : 8'd0;

  function automatic frame_t build_frame(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    frame_t f;
    f[0] = P_HEADER;
    f[1] = x[15:8];
    f[2] = x[7:0];
    f[3] = y[15:8];
    f[4] = y[7:0];
    f[5] = z[15:8];
    f[6] = z[7:0];
    f[7] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
    return f;
  endfunction

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  gap_cnt;
  frame_t      frame_q;
  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;
  frame_t      load_frame;

  // A waiting pending sample always has priority over a fresh strobe in S_IDLE.
  assign load_frame = pend_valid ? build_frame(pend_x, pend_y, pend_z)
                                 : build_frame(x_i, y_i, z_i);

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= 3'd0;
      gap_cnt      <= 8'd0;
      frame_q      <= '0;
      pend_valid   <= 1'b0;
      pend_x       <= 16'd0;
      pend_y       <= 16'd0;
      pend_z       <= 16'd0;
      tx_data_o    <= 8'h00;
      tx_start_o   <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      drop_cnt_o   <= 8'd0;
    end else begin
      tx_start_o   <= 1'b0;
      frame_done_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pend_valid || sample_valid_i) begin
            frame_q    <= load_frame;
            tx_data_o  <= load_frame[0];
            tx_start_o <= 1'b1;
            idx        <= 3'd0;
            busy_o     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (tx_done_tick_i) begin
            if (idx != 3'd7) begin
              idx        <= idx + 3'd1;
              tx_data_o  <= frame_q[idx + 3'd1];
              tx_start_o <= 1'b1;
              state      <= S_START;
            end else begin
              frame_done_o <= 1'b1;
              if (P_GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
              end else begin
                busy_o <= 1'b0;
                state  <= S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Pending buffer: newest sample wins; a lost one is only counted outside S_IDLE.
      if (sample_valid_i) begin
        if (state != S_IDLE || pend_valid) begin
          pend_valid <= 1'b1;
          pend_x     <= x_i;
          pend_y     <= y_i;
          pend_z     <= z_i;
        end
        if (state != S_IDLE && pend_valid && drop_cnt_o != 8'hFF)
          drop_cnt_o <= drop_cnt_o + 8'd1;
      end else if (state == S_IDLE && pend_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_uart_framer.sv
// Self-checking bench for accel_uart_framer: randomized samples, a transaction-level
// reference model of frames/pending/drops, and a behavioural transmitter responder.
module tb_accel_uart_framer;

  typedef logic [0:7][7:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    frame_t f;
    logic [7:0] chk;
    f = {8'hA5, x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0], 8'h00};
    chk = 8'h00;
    for (int i = 0; i < 7; i++) chk = chk ^ f[i];
    f[7] = chk;
    return f;
  endfunction

  // ---------------- DUT A (no gap) ----------------
  logic        sv_a = 1'b0;
  logic [15:0] x_a = '0, y_a = '0, z_a = '0;
  logic        resp_tick = 1'b0, spur_tick = 1'b0;
  logic        tick_a;
  logic [7:0]  data_a, drop_a;
  logic        start_a, busy_a, done_a;
  assign tick_a = resp_tick | spur_tick;

  accel_uart_framer #(.P_HEADER(8'hA5), .P_GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(sv_a),
    .x_i(x_a), .y_i(y_a), .z_i(z_a), .tx_done_tick_i(tick_a),
    .tx_data_o(data_a), .tx_start_o(start_a), .busy_o(busy_a),
    .frame_done_o(done_a), .drop_cnt_o(drop_a));

  // ---------------- DUT B (gap of 4) ----------------
  logic        sv_b = 1'b0;
  logic [15:0] x_b = '0, y_b = '0, z_b = '0;
  logic        tick_b = 1'b0;
  logic [7:0]  data_b, drop_b;
  logic        start_b, busy_b, done_b;

  accel_uart_framer #(.P_HEADER(8'hA5), .P_GAP_CYCLES(4)) u_gap (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(sv_b),
    .x_i(x_b), .y_i(y_b), .z_i(z_b), .tx_done_tick_i(tick_b),
    .tx_data_o(data_b), .tx_start_o(start_b), .busy_o(busy_b),
    .frame_done_o(done_b), .drop_cnt_o(drop_b));

  // ---------------- reference model for DUT A ----------------
  // Idle: take pending first (new strobe refills pending), else the strobe itself.
  // Busy: strobes go to pending, overwrite counts as a drop; 8 done ticks end a frame.
  frame_t      exp_q[$];
  bit          m_busy = 1'b0;
  int          m_ticks = 0;
  bit          m_pend_v = 1'b0;
  logic [15:0] m_px, m_py, m_pz;
  int          m_drops = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_pend_v = 1'b0; m_drops = 0; m_ticks = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (m_pend_v) begin
        exp_q.push_back(make_frame(m_px, m_py, m_pz));
        m_pend_v = sv_a;
        if (sv_a) begin m_px = x_a; m_py = y_a; m_pz = z_a; end
        m_busy = 1'b1; m_ticks = 0;
      end else if (sv_a) begin
        exp_q.push_back(make_frame(x_a, y_a, z_a));
        m_busy = 1'b1; m_ticks = 0;
      end
    end else begin
      if (sv_a) begin
        if (m_pend_v && m_drops < 255) m_drops++;
        m_pend_v = 1'b1; m_px = x_a; m_py = y_a; m_pz = z_a;
      end
      if (tick_a) begin
        m_ticks++;
        if (m_ticks == 8) m_busy = 1'b0;
      end
    end
  end

  // ---------------- transmitter responder + monitor for DUT A ----------------
  int         ncyc = 0, byte_idx = 0, resp_cnt = 0, lat = 10;
  int         last_tick_c = 0, done_c = 0, hdr_gap = 0, frames_done = 0, headers = 0;
  bit         prev_start = 1'b0, exp_done_next = 1'b0;
  frame_t     cur_frame = '0;
  logic [7:0] cur_byte = '0, hdr_byte = '0;
  logic [7:0] got_bytes [8];

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rst_n) begin
      resp_tick = 1'b0; resp_cnt = 0; byte_idx = 0; exp_done_next = 1'b0; prev_start = 1'b0;
    end else begin
      if (exp_done_next) check("frame_done_pulse", done_a, 1'b1);
      else if (done_a)   check("frame_done_extra", done_a, 1'b0);
      if (done_a) begin done_c = ncyc; frames_done++; end
      exp_done_next = 1'b0;

      resp_tick = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_tick = 1'b1;
          check("data_stable", data_a, cur_byte);
          last_tick_c = ncyc;
          if (byte_idx == 8) begin exp_done_next = 1'b1; byte_idx = 0; end
        end
      end

      if (start_a) begin
        check("start_width", prev_start, 1'b0);
        check("tx_idle_at_start", resp_cnt, 0);
        if (byte_idx == 0) begin
          if (exp_q.size() == 0) begin
            check("expected_frame_avail", 1'b0, 1'b1);
            cur_frame = '0;
          end else begin
            cur_frame = exp_q.pop_front();
          end
          hdr_gap = ncyc - done_c; hdr_byte = data_a; headers++;
        end else begin
          check("start_latency", ncyc - last_tick_c, 1);
        end
        check($sformatf("byte%0d", byte_idx), data_a, cur_frame[byte_idx]);
        got_bytes[byte_idx] = data_a;
        cur_byte = data_a;
        byte_idx++;
        resp_cnt = lat;
      end
      prev_start = start_a;
    end
  end

  // ---------------- responder + recorder for DUT B ----------------
  int         b_ncyc = 0, b_cnt = 0, b_starts = 0, b_ticks = 0, b_end1_c = -1, b_hdr2_c = -1;
  logic [7:0] b_bytes [16];

  initial forever begin
    @(negedge clk);
    b_ncyc++;
    if (rst_n) begin
      tick_b = 1'b0;
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          tick_b = 1'b1; b_ticks++;
          if (b_ticks == 8) b_end1_c = b_ncyc;
        end
      end
      if (start_b) begin
        if (b_starts < 16) b_bytes[b_starts] = data_b;
        if (b_starts == 8) b_hdr2_c = b_ncyc;
        b_starts++;
        b_cnt = 3;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe_a(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sv_a = 1'b1; x_a = x; y_a = y; z_a = z;
    @(negedge clk);
    sv_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sv_b = 1'b1; x_b = x; y_b = y; z_b = z;
    @(negedge clk);
    sv_b = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    do begin @(negedge clk); g++; end
    while (!(!m_busy && !m_pend_v && exp_q.size() == 0 && byte_idx == 0 &&
             resp_cnt == 0 && !busy_a) && g < 5000);
    if (g >= 5000) check({tag, "_timeout"}, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_byte(input int n);
    int g = 0;
    while (byte_idx != n && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) check("wait_byte_timeout", 1'b0, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] basic_exp [8];
  logic [15:0] px, py, pz, qx, qy, qz, dx, dy, dz;
  frame_t fp, fq;
  int f0, h0, g;
  bit seen;

  initial begin
    basic_exp = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h1A};

    // Reset state
    #1;
    check("rst_tx_data", data_a, 8'h00);
    check("rst_tx_start", start_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_frame_done", done_a, 1'b0);
    check("rst_drop", drop_a, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Gap of 4: two back-to-back frames on DUT B, header 6 cycles after last tick
    px = 16'($urandom); py = 16'($urandom); pz = 16'($urandom);
    qx = 16'($urandom); qy = 16'($urandom); qz = 16'($urandom);
    strobe_b(px, py, pz);
    g = 0;
    while (b_starts < 3 && g < 500) begin @(negedge clk); g++; end
    strobe_b(qx, qy, qz);
    g = 0;
    while (b_ticks < 16 && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) check("gap_frames_timeout", 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("gap_header_delay", b_hdr2_c - b_end1_c, 6);
    fp = make_frame(px, py, pz);
    fq = make_frame(qx, qy, qz);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gap_f1_byte%0d", i), b_bytes[i], fp[i]);
      check($sformatf("gap_f2_byte%0d", i), b_bytes[i+8], fq[i]);
    end
    check("gap_drop", drop_b, 8'd0);

    // Basic frame, 10-cycle transmitter
    lat = 10;
    f0 = frames_done;
    strobe_a(16'h1234, 16'hABCD, 16'h00FF);
    wait_drain("basic");
    for (int i = 0; i < 8; i++) check($sformatf("basic_byte%0d", i), got_bytes[i], basic_exp[i]);
    check("basic_done_count", frames_done - f0, 1);

    // Pending buffer: B arrives during byte 3 of A
    h0 = headers;
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    wait_byte(4);
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    wait_drain("pending");
    check("pending_headers", headers - h0, 2);
    check("pending_restart_delay", hdr_gap, 1);
    check("pending_drop", drop_a, 8'd0);

    // Overwrite: B, C, D during A; next frame carries D
    dx = 16'($urandom); dy = 16'($urandom); dz = 16'($urandom);
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    wait_byte(2);
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    strobe_a(dx, dy, dz);
    wait_drain("overwrite");
    check("overwrite_drop", drop_a, 8'd2);
    check("overwrite_x_hi", got_bytes[1], dx[15:8]);
    check("overwrite_y_lo", got_bytes[4], dy[7:0]);
    check("overwrite_z_lo", got_bytes[6], dz[7:0]);

    // Saturation: 300 consecutive strobes
    lat = int'($urandom_range(1, 4));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sv_a = 1'b1; x_a = 16'($urandom); y_a = 16'($urandom); z_a = 16'($urandom);
    end
    @(negedge clk);
    sv_a = 1'b0;
    wait_drain("saturate");
    check("saturate_drop", drop_a, 8'hFF);
    check("saturate_drop_model", drop_a, m_drops);

    // Spurious done tick in S_IDLE
    @(negedge clk); spur_tick = 1'b1;
    @(negedge clk); spur_tick = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (start_a || busy_a) seen = 1'b1; end
    check("spurious_tick_start", seen, 1'b0);

    // Randomized frames with random transmitter latency and spacing
    for (int n = 0; n < 8; n++) begin
      lat = int'($urandom_range(1, 6));
      strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_drain("random");
    check("random_drop_model", drop_a, m_drops);

    // Reset mid-frame
    lat = 10;
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    wait_byte(5);
    f0 = frames_done;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_data", data_a, 8'h00);
    check("midrst_tx_start", start_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_frame_done", done_a, 1'b0);
    check("midrst_drop", drop_a, 8'h00);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (done_a) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done_a) seen = 1'b1; end
    check("midrst_no_done", seen, 1'b0);
    strobe_a(16'($urandom), 16'($urandom), 16'($urandom));
    wait_drain("after_reset");
    check("after_reset_header", hdr_byte, 8'hA5);
    check("after_reset_done_count", frames_done - f0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
